bht_predictor: RTL and testbench

Branch history table for the fetch stage. It produces the predicted next PC and the 2-bit prediction state that travel down the pipeline alongside each instruction. It also resolves the branch in EX: it compares the carried prediction against the actual outcome, asserts `predict_fail` to flush the IF/ID register and redirect fetch, and updates the table. It sits between the PC register and the IF/ID pipeline register, and receives resolution inputs from EX.

---
 rtl/bht_predictor.sv | 139 +++++++++++++
 tb/tb_bht_predictor.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_predictor.sv
// Branch history table: combinational next-PC prediction at fetch, branch resolution and table update from EX.
// Optional build macro BHT_STATS_EN adds branch / misprediction counter outputs.
module bht_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] pc_predict,
  output logic [1:0]  binary_predict,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc_4,
  input  logic [31:0] ex_pc_predict,
  input  logic [1:0]  ex_binary_predict,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        predict_fail,
  output logic [31:0] pc_redirect
`ifdef BHT_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic              valid_reg  [ENTRIES];
  logic [TAG_W-1:0]  tag_reg    [ENTRIES];
  logic [31:0]       target_reg [ENTRIES];
  logic [1:0]        cnt_reg    [ENTRIES];

  // Fetch-side lookup
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;

  assign lk_idx = pc[IDX_W+1:2];
  assign lk_tag = pc[31:IDX_W+2];
  assign lk_hit = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);

  always_comb begin
    pc_predict     = pc + 32'd4;
    binary_predict = 2'b01;
    if (lk_hit) begin
      binary_predict = cnt_reg[lk_idx];
      if (cnt_reg[lk_idx][1]) begin
        pc_predict = target_reg[lk_idx];
      end
    end
  end

  // EX-side resolution
  logic [31:0] actual_next;
  logic        resolve_en;

  assign actual_next = ex_taken ? ex_target : ex_pc_4;
  assign resolve_en  = ex_valid && rst_n;

  always_comb begin
    predict_fail = 1'b0;
    pc_redirect  = 32'd0;
    if (resolve_en) begin
      predict_fail = (ex_pc_predict != actual_next);
      pc_redirect  = actual_next;
    end
  end

  // Update addressing derived from the branch's own PC
  logic [31:0]      bpc;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       cnt_next;

  assign bpc     = ex_pc_4 - 32'd4;
  assign upd_idx = bpc[IDX_W+1:2];
  assign upd_tag = bpc[31:IDX_W+2];
  assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

  // Counter update starts from the state carried with the instruction, not the table copy.
  always_comb begin
    cnt_next = ex_binary_predict;
    if (ex_taken) begin
      if (ex_binary_predict != 2'b11) cnt_next = ex_binary_predict + 2'd1;
    end else begin
      if (ex_binary_predict != 2'b00) cnt_next = ex_binary_predict - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        cnt_reg[i]   <= 2'b01;
      end
    end else if (ex_valid) begin
      if (upd_hit) begin
        cnt_reg[upd_idx] <= cnt_next;
      end else if (ex_taken) begin
        valid_reg[upd_idx] <= 1'b1;
        cnt_reg[upd_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target carry no reset value; only the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (rst_n && ex_valid && ex_taken) begin
      target_reg[upd_idx] <= ex_target;
      if (!upd_hit) begin
        tag_reg[upd_idx] <= upd_tag;
      end
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] stat_branches_reg;
  logic [31:0] stat_mispredicts_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_reg    <= 32'd0;
      stat_mispredicts_reg <= 32'd0;
    end else begin
      if (ex_valid)     stat_branches_reg    <= stat_branches_reg + 32'd1;
      if (predict_fail) stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_reg;
  assign stat_mispredicts = stat_mispredicts_reg;
`endif

  logic unused_bits;
  assign unused_bits = ^{pc[1:0], bpc[1:0]};

endmodule

// File: tb/tb_bht_predictor.sv
// Directed testbench for bht_predictor: reset, allocation, counter updates, saturation, aliasing and wrap cases.
`timescale 1ns/1ps
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] pc_predict;
  logic [1:0]  binary_predict;
  logic        ex_valid;
  logic [31:0] ex_pc_4;
  logic [31:0] ex_pc_predict;
  logic [1:0]  ex_binary_predict;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        predict_fail;
  logic [31:0] pc_redirect;
`ifdef BHT_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bht_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc                (pc),
    .pc_predict        (pc_predict),
    .binary_predict    (binary_predict),
    .ex_valid          (ex_valid),
    .ex_pc_4           (ex_pc_4),
    .ex_pc_predict     (ex_pc_predict),
    .ex_binary_predict (ex_binary_predict),
    .ex_taken          (ex_taken),
    .ex_target         (ex_target),
    .predict_fail      (predict_fail),
    .pc_redirect       (pc_redirect)
`ifdef BHT_STATS_EN
    ,
    .stat_branches     (stat_branches),
    .stat_mispredicts  (stat_mispredicts)
`endif
  );

  // Advance one clock; inputs change 1ns after the edge, checks happen 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] p4, input logic [31:0] pp,
                          input logic [1:0] bp, input logic tk, input logic [31:0] tgt);
    ex_valid          = v;
    ex_pc_4           = p4;
    ex_pc_predict     = pp;
    ex_binary_predict = bp;
    ex_taken          = tk;
    ex_target         = tgt;
    #2;
    $display("[TB] ex v=%0b pc_4=%h pred=%h bp=%b taken=%0b tgt=%h -> predict_fail=%0b redirect=%h",
             v, p4, pp, bp, tk, tgt, predict_fail, pc_redirect);
  endtask

  task automatic lookup(input logic [31:0] a);
    pc = a;
    #2;
    $display("[TB] lookup pc=%h -> pc_predict=%h binary_predict=%b", a, pc_predict, binary_predict);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pc = 32'h0000_0040;
    drive_ex(1'b1, 32'h44, 32'h44, 2'b01, 1'b1, 32'h200);
    tests_run++;
    if (predict_fail !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fail_gated: got %0b expected 0", predict_fail);
    end
    tests_run++;
    if (pc_redirect !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_redirect_gated: got %h expected 00000000", pc_redirect);
    end
    tick();
    tick();
    rst_n = 1'b1;
    drive_ex(1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 32'h0);
    lookup(32'h0000_0040);
    tests_run++;
    if (pc_predict !== 32'h0000_0044) begin
      tests_failed++;
      $display("FAIL reset_pc_predict: got %h expected 00000044", pc_predict);
    end
    tests_run++;
    if (binary_predict !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_binary_predict: got %b expected 01", binary_predict);
    end
    tests_run++;
    if (predict_fail !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_predict_fail: got %0b expected 0", predict_fail);
    end
  endtask

  task automatic test_allocate();
    tick();
    pc = 32'h0000_0040;
    drive_ex(1'b1, 32'h44, 32'h44, 2'b01, 1'b1, 32'h100);
    tests_run++;
    if (predict_fail !== 1'b1 || pc_redirect !== 32'h100) begin
      tests_failed++;
      $display("FAIL alloc_resolve: got fail=%0b redirect=%h expected fail=1 redirect=00000100",
               predict_fail, pc_redirect);
    end
    tests_run++;
    if (pc_predict !== 32'h44) begin
      tests_failed++;
      $display("FAIL alloc_same_cycle_lookup: got %h expected 00000044", pc_predict);
    end
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 32'h0);
    lookup(32'h0000_0040);
    tests_run++;
    if (pc_predict !== 32'h100 || binary_predict !== 2'b10) begin
      tests_failed++;
      $display("FAIL alloc_lookup: got pred=%h bp=%b expected pred=00000100 bp=10",
               pc_predict, binary_predict);
    end
  endtask

  task automatic test_not_taken();
    tick();
    drive_ex(1'b1, 32'h44, 32'h100, 2'b10, 1'b0, 32'h100);
    tests_run++;
    if (predict_fail !== 1'b1 || pc_redirect !== 32'h44) begin
      tests_failed++;
      $display("FAIL nt_resolve: got fail=%0b redirect=%h expected fail=1 redirect=00000044",
               predict_fail, pc_redirect);
    end
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 32'h0);
    lookup(32'h0000_0040);
    tests_run++;
    if (pc_predict !== 32'h44 || binary_predict !== 2'b01) begin
      tests_failed++;
      $display("FAIL nt_lookup: got pred=%h bp=%b expected pred=00000044 bp=01",
               pc_predict, binary_predict);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      tick();
      drive_ex(1'b1, 32'h44, 32'h100, 2'b11, 1'b1, 32'h100);
      tests_run++;
      if (predict_fail !== 1'b0) begin
        tests_failed++;
        $display("FAIL sat_taken_fail[%0d]: got %0b expected 0", k, predict_fail);
      end
    end
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 32'h0);
    lookup(32'h0000_0040);
    tests_run++;
    if (binary_predict !== 2'b11 || pc_predict !== 32'h100) begin
      tests_failed++;
      $display("FAIL sat_high: got bp=%b pred=%h expected bp=11 pred=00000100",
               binary_predict, pc_predict);
    end
    tick();
    drive_ex(1'b1, 32'h44, 32'h44, 2'b00, 1'b0, 32'h100);
    tests_run++;
    if (predict_fail !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_low_fail: got %0b expected 0", predict_fail);
    end
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 32'h0);
    lookup(32'h0000_0040);
    tests_run++;
    if (binary_predict !== 2'b00 || pc_predict !== 32'h44) begin
      tests_failed++;
      $display("FAIL sat_low: got bp=%b pred=%h expected bp=00 pred=00000044",
               binary_predict, pc_predict);
    end
  endtask

  task automatic test_alias();
    tick();
    drive_ex(1'b1, 32'h84, 32'h84, 2'b01, 1'b1, 32'h300);
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 32'h0);
    lookup(32'h0000_0040);
    tests_run++;
    if (pc_predict !== 32'h44 || binary_predict !== 2'b01) begin
      tests_failed++;
      $display("FAIL alias_old_miss: got pred=%h bp=%b expected pred=00000044 bp=01",
               pc_predict, binary_predict);
    end
    lookup(32'h0000_0080);
    tests_run++;
    if (pc_predict !== 32'h300 || binary_predict !== 2'b10) begin
      tests_failed++;
      $display("FAIL alias_new_hit: got pred=%h bp=%b expected pred=00000300 bp=10",
               pc_predict, binary_predict);
    end
  endtask

  task automatic test_miss_not_taken();
    tick();
    drive_ex(1'b1, 32'h14, 32'h14, 2'b01, 1'b0, 32'h700);
    tests_run++;
    if (predict_fail !== 1'b0 || pc_redirect !== 32'h14) begin
      tests_failed++;
      $display("FAIL miss_nt_resolve: got fail=%0b redirect=%h expected fail=0 redirect=00000014",
               predict_fail, pc_redirect);
    end
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 32'h0);
    lookup(32'h0000_0010);
    tests_run++;
    if (pc_predict !== 32'h14 || binary_predict !== 2'b01) begin
      tests_failed++;
      $display("FAIL miss_nt_no_write: got pred=%h bp=%b expected pred=00000014 bp=01",
               pc_predict, binary_predict);
    end
  endtask

  task automatic test_wrap();
    lookup(32'hFFFF_FFFC);
    tests_run++;
    if (pc_predict !== 32'h0000_0000 || binary_predict !== 2'b01) begin
      tests_failed++;
      $display("FAIL wrap_pc: got pred=%h bp=%b expected pred=00000000 bp=01",
               pc_predict, binary_predict);
    end
  endtask

  task automatic test_reset_inflight();
    tick();
    rst_n = 1'b0;
    drive_ex(1'b1, 32'hC4, 32'hC4, 2'b01, 1'b1, 32'h500);
    tests_run++;
    if (predict_fail !== 1'b0) begin
      tests_failed++;
      $display("FAIL inflight_fail_gated: got %0b expected 0", predict_fail);
    end
    tick();
    rst_n = 1'b1;
    drive_ex(1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 32'h0);
    lookup(32'h0000_00C0);
    tests_run++;
    if (pc_predict !== 32'hC4 || binary_predict !== 2'b01) begin
      tests_failed++;
      $display("FAIL inflight_no_write: got pred=%h bp=%b expected pred=000000c4 bp=01",
               pc_predict, binary_predict);
    end
    lookup(32'h0000_0080);
    tests_run++;
    if (pc_predict !== 32'h84 || binary_predict !== 2'b01) begin
      tests_failed++;
      $display("FAIL inflight_cleared: got pred=%h bp=%b expected pred=00000084 bp=01",
               pc_predict, binary_predict);
    end
  endtask

`ifdef BHT_STATS_EN
  task automatic test_stats();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive_ex(1'b1, 32'h204, 32'h204, 2'b01, 1'b0, 32'h0);
    tick();
    drive_ex(1'b1, 32'h208, 32'h900, 2'b01, 1'b0, 32'h0);
    tick();
    drive_ex(1'b1, 32'h20C, 32'h20C, 2'b01, 1'b0, 32'h0);
    tick();
    drive_ex(1'b1, 32'h210, 32'h210, 2'b01, 1'b1, 32'hA00);
    tick();
    drive_ex(1'b1, 32'h214, 32'h214, 2'b01, 1'b0, 32'h0);
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 32'h0);
    tests_run++;
    if (stat_branches !== 32'd5 || stat_mispredicts !== 32'd2) begin
      tests_failed++;
      $display("FAIL stats_count: got br=%0d mp=%0d expected br=5 mp=2", stat_branches, stat_mispredicts);
    end
    rst_n = 1'b0;
    tick();
    #2;
    tests_run++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      tests_failed++;
      $display("FAIL stats_reset: got br=%0d mp=%0d expected 0 0", stat_branches, stat_mispredicts);
    end
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    pc = 32'h0;
    ex_valid = 1'b0;
    ex_pc_4 = 32'h0;
    ex_pc_predict = 32'h0;
    ex_binary_predict = 2'b01;
    ex_taken = 1'b0;
    ex_target = 32'h0;
    tick();
    test_reset();
    test_allocate();
    test_not_taken();
    test_saturation();
    test_alias();
    test_miss_not_taken();
    test_wrap();
    test_reset_inflight();
`ifdef BHT_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
